// File: rtl/audio_pkg.sv
// Shared audio effect-chain definitions.
// Sample width, envelope state encoding and release shift base.
package audio_pkg;

  localparam int SAMPLE_W = 16;
  localparam int MAG_W = SAMPLE_W - 1;
  localparam int REL_SHIFT_BASE = 4;
  localparam int HOLD_W = 16;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ATTACK  = 2'd1,
    S_HOLD    = 2'd2,
    S_RELEASE = 2'd3
  } env_state_e;

  // A zero step would stall the envelope short of its target.
  function automatic logic [MAG_W-1:0] min1(
    input logic [MAG_W-1:0] v
  );
    return (v == '0) ? MAG_W'(1) : v;
  endfunction

endpackage

// File: rtl/envelope_follower_if.sv
// Sample stream bundle for the envelope follower.
// master drives samples in, slave returns delayed sample and envelope.
interface envelope_follower_if;
  import audio_pkg::*;

  logic                       i_valid;
  logic                       i_enable;
  logic [2:0]                 i_release;
  logic signed [SAMPLE_W-1:0] i_data;
  logic signed [SAMPLE_W-1:0] o_data;
  logic [SAMPLE_W-1:0]        o_env;
  logic [1:0]                 o_state;
  logic                       o_valid;

  modport master (
    output i_valid,
    output i_enable,
    output i_release,
    output i_data,
    input  o_data,
    input  o_env,
    input  o_state,
    input  o_valid
  );

  modport slave (
    input  i_valid,
    input  i_enable,
    input  i_release,
    input  i_data,
    output o_data,
    output o_env,
    output o_state,
    output o_valid
  );

endinterface

// File: rtl/abs_sat16.sv
// Signed 16-bit to unsigned 15-bit magnitude.
// The most negative code saturates to full scale.
module abs_sat16
  import audio_pkg::*;
(
  input  logic signed [SAMPLE_W-1:0] data,
  output logic [MAG_W-1:0]           mag
);

  logic [SAMPLE_W-1:0] raw;
  logic [SAMPLE_W-1:0] neg;

  assign raw = data;
  assign neg = (~raw) + SAMPLE_W'(1);

  // Only -32768 negates to a value with the top bit still set.
  always_comb begin
    mag = raw[MAG_W-1:0];
    if (raw[SAMPLE_W-1]) begin
      if (neg[SAMPLE_W-1]) mag = '1;
      else                 mag = neg[MAG_W-1:0];
    end
  end

endmodule

// File: rtl/envelope_follower.sv
// Peak envelope tracker: fast attack, fixed hold, shift-based release.
// Envelope and delayed sample are presented one clock after the input.
module envelope_follower
  import audio_pkg::*;
#(
  parameter int ATTACK_SHIFT = 2,
  parameter int HOLD_SAMPLES = 480
) (
  input logic                i_clk,
  input logic                i_rst,
  envelope_follower_if.slave bus
);

  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_SAMPLES);

  logic [MAG_W-1:0]  mag;
  logic [MAG_W-1:0]  env;
  logic [MAG_W-1:0]  diff;
  logic [MAG_W-1:0]  atk_step;
  logic [MAG_W-1:0]  rel_step;
  logic [3:0]        rel_sh;
  logic [HOLD_W-1:0] hold_cnt;
  env_state_e        state;

  abs_sat16 u_abs (
    .data (bus.i_data),
    .mag  (mag)
  );

  assign diff     = mag - env;
  assign atk_step = min1(diff >> ATTACK_SHIFT);
  assign rel_sh   = 4'(REL_SHIFT_BASE) + {1'b0, bus.i_release};
  assign rel_step = min1(env >> rel_sh);

  assign bus.o_env   = {1'b0, env};
  assign bus.o_state = state;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      env         <= '0;
      hold_cnt    <= '0;
      state       <= S_IDLE;
      bus.o_data  <= '0;
      bus.o_valid <= 1'b0;
    end else begin
      bus.o_valid <= bus.i_valid;
      if (bus.i_valid) bus.o_data <= bus.i_data;

      // Disable overrides any sample arriving in the same cycle.
      if (!bus.i_enable) begin
        env      <= '0;
        hold_cnt <= '0;
        state    <= S_IDLE;
      end else if (bus.i_valid) begin
        unique case (1'b1)
          (mag > env): begin
            env      <= env + atk_step;
            hold_cnt <= HOLD_INIT;
            state    <= S_ATTACK;
          end
          (mag <= env && hold_cnt != '0): begin
            hold_cnt <= hold_cnt - HOLD_W'(1);
            state    <= S_HOLD;
          end
          (mag <= env && hold_cnt == '0 && env != '0): begin
            env   <= env - rel_step;
            state <= S_RELEASE;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_envelope_follower.sv
// Scoreboard bench for envelope_follower.
// A reference model queues expected outputs as samples are driven.
module tb_envelope_follower;
  import audio_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  envelope_follower_if bus ();

  envelope_follower #(
    .ATTACK_SHIFT (2),
    .HOLD_SAMPLES (4)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  typedef struct {
    int data;
    int env;
    int state;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   errors = 0;
  int   checks = 0;
  int   pulses = 0;
  int   m_env  = 0;
  int   m_hold = 0;
  int   m_state = 0;

  task automatic check(string tag, int got, int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  task automatic model(bit v, bit en, int rel, int data);
    int mag;
    int s;
    if (!en) begin
      m_env   = 0;
      m_hold  = 0;
      m_state = 0;
    end else if (v) begin
      mag = (data < 0) ? -data : data;
      if (mag > 32767) mag = 32767;
      if (mag > m_env) begin
        s = (mag - m_env) / 4;
        if (s < 1) s = 1;
        m_env   = m_env + s;
        m_hold  = 4;
        m_state = 1;
      end else if (m_hold != 0) begin
        m_hold  = m_hold - 1;
        m_state = 2;
      end else if (m_env != 0) begin
        s = m_env >> (4 + rel);
        if (s < 1) s = 1;
        m_env   = m_env - s;
        m_state = 3;
      end else begin
        m_state = 0;
      end
    end
  endtask

  task automatic cycle(bit v, bit en, int rel, int data);
    exp_t x;
    @(negedge clk);
    bus.i_valid   = v;
    bus.i_enable  = en;
    bus.i_release = 3'(rel);
    bus.i_data    = 16'(data);
    model(v, en, rel, data);
    if (v) begin
      x.data  = data;
      x.env   = m_env;
      x.state = m_state;
      sb.push_back(x);
    end
    @(posedge clk);
    #2;
  endtask

  always @(posedge clk) begin
    #1;
    if (bus.o_valid === 1'b1) begin
      pulses++;
      if (sb.size() == 0) begin
        check("sb_underflow", 1, 0);
      end else begin
        e = sb.pop_front();
        check("sb_data", int'(bus.o_data), e.data);
        check("sb_env", int'(bus.o_env), e.env);
        check("sb_state", int'(bus.o_state), e.state);
      end
    end
  end

  initial begin
    rst           = 1'b1;
    bus.i_valid   = 1'b0;
    bus.i_enable  = 1'b0;
    bus.i_release = 3'd0;
    bus.i_data    = '0;
    repeat (2) @(negedge clk);
    check("rst_env", int'(bus.o_env), 0);
    check("rst_state", int'(bus.o_state), 0);
    check("rst_valid", int'(bus.o_valid), 0);
    check("rst_data", int'(bus.o_data), 0);
    rst = 1'b0;

    // Attack
    cycle(1, 1, 0, 16000);
    check("t1_env0", int'(bus.o_env), 4000);
    check("t1_st0", int'(bus.o_state), 1);
    check("t1_vld0", int'(bus.o_valid), 1);
    cycle(1, 1, 0, 16000);
    check("t1_env1", int'(bus.o_env), 7000);
    check("t1_st1", int'(bus.o_state), 1);
    cycle(0, 1, 0, 0);
    check("t1_vld_gap", int'(bus.o_valid), 0);
    check("t1_env_held", int'(bus.o_env), 7000);

    // Hold and release
    for (int i = 0; i < 80 && m_env != 16000; i++)
      cycle(1, 1, 0, 16000);
    check("t2_pre", int'(bus.o_env), 16000);
    for (int i = 0; i < 4; i++) begin
      cycle(1, 1, 0, 0);
      check("t2_hold_env", int'(bus.o_env), 16000);
      check("t2_hold_st", int'(bus.o_state), 2);
    end
    cycle(1, 1, 0, 0);
    check("t2_rel0", int'(bus.o_env), 15000);
    check("t2_rel_st", int'(bus.o_state), 3);
    cycle(1, 1, 0, 0);
    check("t2_rel1", int'(bus.o_env), 14063);

    // Saturation
    for (int i = 0; i < 80 && m_env != 32766; i++)
      cycle(1, 1, 0, 32766);
    check("t3_pre", int'(bus.o_env), 32766);
    cycle(1, 1, 0, -32768);
    check("t3_sat", int'(bus.o_env), 32767);
    check("t3_msb", int'(bus.o_env[15]), 0);

    // Minimum release step
    cycle(0, 0, 0, 0);
    check("t3_clr", int'(bus.o_env), 0);
    for (int i = 0; i < 40 && m_env != 10; i++)
      cycle(1, 1, 7, 10);
    check("t3_ten", int'(bus.o_env), 10);
    for (int i = 0; i < 4; i++)
      cycle(1, 1, 7, 0);
    for (int k = 9; k >= 0; k--) begin
      cycle(1, 1, 7, 0);
      check("t3_min_env", int'(bus.o_env), k);
      check("t3_min_st", int'(bus.o_state), 3);
    end
    cycle(1, 1, 7, 0);
    check("t3_idle", int'(bus.o_state), 0);

    // Bypass
    cycle(0, 0, 0, 0);
    cycle(1, 1, 0, 16000);
    cycle(1, 1, 0, 16000);
    check("t4_pre", int'(bus.o_env), 7000);
    cycle(1, 0, 0, -1234);
    check("t4_data", int'(bus.o_data), -1234);
    check("t4_env", int'(bus.o_env), 0);
    check("t4_st", int'(bus.o_state), 0);
    cycle(0, 1, 0, 0);

    // Back-to-back samples
    pulses = 0;
    for (int i = 0; i < 8; i++)
      cycle(1, 1, i, (i + 1) * 1000 - 5000);
    cycle(0, 1, 0, 0);
    cycle(0, 1, 0, 0);
    check("t5_pulses", pulses, 8);
    check("t5_pre_data", int'(bus.o_data), 3000);

    // Asynchronous reset between edges
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("t5_ar_env", int'(bus.o_env), 0);
    check("t5_ar_data", int'(bus.o_data), 0);
    check("t5_ar_st", int'(bus.o_state), 0);
    check("t5_ar_vld", int'(bus.o_valid), 0);
    m_env   = 0;
    m_hold  = 0;
    m_state = 0;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    cycle(1, 1, 0, 16000);
    check("t5_post", int'(bus.o_env), 4000);
    cycle(0, 1, 0, 0);

    check("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/envelope_follower.md
# envelope_follower

Amplitude detector for the audio effect chain: the demodulating counterpart to the tremolo modulator. For each valid signed 16-bit sample it tracks the signal envelope with a fast attack, a fixed hold window and a selectable exponential release. It then emits the envelope alongside a latency-matched copy of the sample. Downstream dynamics blocks (noise gate, compressor) and the LED level meter consume `o_env`.

## Interface

- `ATTACK_SHIFT`, default 2: attack smoothing; each attack step adds `(mag-env) >> ATTACK_SHIFT`.
- `HOLD_SAMPLES`, default 480: number of valid samples the envelope is held after the last attack (10 ms at 48 kHz); range 1..65535.
- `i_clk`, input, 1: system clock; all logic on the rising edge.
- `i_rst`, input, 1: reset, asynchronous and active-high.
- `i_valid`, input, 1: one-cycle strobe marking `i_data` as a new sample.
- `i_enable`, input, 1: effect enable; when low the block bypasses and clears its state.
- `i_release`, input, 3: release shift select; effective shift is `4 + i_release` (4..11).
- `i_data`, input, 16, signed: audio sample.
- `o_data`, output, 16, signed: registered copy of `i_data`.
- `o_env`, output, 16: envelope magnitude, 0..32767; MSB is always 0.
- `o_state`, output, 2: current state encoding, for debug and meter use.
- `o_valid`, output, 1: registered `i_valid`.

## Operation

- **Magnitude:** `mag = |i_data|`, saturated so that -32768 maps to 32767. `mag` is 15-bit unsigned.
- **States:** `S_IDLE`=0, `S_ATTACK`=1, `S_HOLD`=2, `S_RELEASE`=3. State changes only on a cycle with `i_valid && i_enable`.
- **Update rule,** evaluated per enabled valid sample with priority top-down:
  - `mag > env`:
    - `step = (mag-env) >> ATTACK_SHIFT`, forced to a minimum of 1.
    - `env += step`.
    - `hold_cnt = HOLD_SAMPLES`.
    - Next state is `S_ATTACK`.
  - `hold_cnt != 0`:
    - `hold_cnt -= 1`; `env` is unchanged.
    - Next state is `S_HOLD`.
  - `env != 0`:
    - `step = env >> (4+i_release)`, forced to a minimum of 1.
    - `env -= step`.
    - Next state is `S_RELEASE`.
  - Otherwise: `env` stays 0 and the next state is `S_IDLE`.
- **Bounds:**
  - The attack step never overshoots `mag`, because `step <= mag-env`.
  - The release never underflows, because `step <= env`.
  - `env` therefore stays within 0..32767.
- **Arithmetic:**
  - `env` and the difference are 15-bit unsigned; `hold_cnt` is 16-bit.
  - Shifts are logical.
  - No signed arithmetic except the abs.
- **`i_release`** is sampled on each valid sample; a change takes effect on the next release step.
- **Disabled (`i_enable` = 0):**
  - `env`, `hold_cnt` and state clear to 0 / `S_IDLE` on the next clock edge.
  - `o_data` and `o_valid` still follow `i_data` and `i_valid`.
- If `i_enable` falls in the same cycle as `i_valid`, disable wins: the envelope clears and the sample is passed through.

## Timing

- Latency is 1 cycle: `o_valid`, `o_data` and `o_env` all reflect the sample presented one edge earlier.
- `o_env` and `o_state` hold their values between valid samples.
- `o_data` and `o_valid` register every cycle; `o_data` captures `i_data` only when `i_valid` = 1.
- `i_valid` may be asserted on consecutive cycles, so the block must sustain one sample per clock.
- Reset values: `o_data`=0, `o_env`=0, `o_state`=`S_IDLE`, `o_valid`=0, `hold_cnt`=0.
- Asserting `i_rst` mid-operation clears everything immediately and asynchronously. The first sample after release of reset is treated as starting from `env`=0.

## Structure

- Shared `audio_pkg` holds:
  - `SAMPLE_W` = 16.
  - The `env_state_e` enum with the four states above.
  - `REL_SHIFT_BASE` = 4.
- One sub-module, `abs_sat16`: combinational signed 16-bit to saturated unsigned 15-bit magnitude. It is reusable by the meter and compressor.
- The state register, envelope register, hold counter and output registers live in `envelope_follower`.

## Test plan

Unless noted, the parameters are `ATTACK_SHIFT`=2 and `HOLD_SAMPLES`=4.

1. **Attack:** reset, enable, two valid samples of 16000.
   - Required `o_env`: 4000 then 7000.
   - `o_state` is 1 both times; `o_valid` pulses 1 cycle after each input.
2. **Hold and release:** from `env`=16000, feed samples of 0 with `i_release`=0.
   - Required `o_env`: 16000 for 4 samples (state 2), then 15000 and 14063 (state 3).
3. **Saturation and minimum step:**
   - Preload `env`=32766 and feed -32768: `o_env` must read 32767, never 32768.
   - From `env`=10 in release with `i_release`=7: `o_env` steps 9, 8, ... down to 0, then state returns to 0.
4. **Bypass:**
   - With `env`=7000, drop `i_enable` on the same cycle as a valid sample of -1234.
   - Required: `o_data`=-1234, `o_env`=0, state 0.
5. **Back-to-back and async reset:**
   - Drive `i_valid` high for 8 consecutive cycles: there must be exactly 8 `o_valid` pulses.
   - Pulse `i_rst` between clock edges: all outputs must go to 0 immediately.
